// File: rtl/spi_frame_arbiter.sv
// spi_frame_arbiter
// Round-robin scheduler that shares one 16-bit SPI frame engine between
// NREQ requesters. A frame is accepted on a valid/ready handshake, the
// engine is launched with a one-cycle start pulse plus a one-hot select,
// and the arbiter waits for done (or a timeout) before enforcing a
// CS-high gap and returning to IDLE for the next grant.

module spi_frame_arbiter #(
  parameter int NREQ           = 2,
  parameter int FRAME_W        = 16,
  parameter int GAP_CYCLES     = 20,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*FRAME_W-1:0] req_frame,
  output logic [NREQ-1:0]         req_ready,
  output logic                    spi_start,
  output logic [FRAME_W-1:0]      spi_frame,
  output logic [NREQ-1:0]         spi_sel,
  input  logic                    spi_done,
  output logic                    arb_busy,
  output logic                    timeout_pulse,
  output logic [7:0]              timeout_count
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]      sel_q, sel_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [7:0]           to_cnt_q, to_cnt_d;

  logic                 grant_found;
  logic [PTR_W-1:0]     grant_idx;
  logic [NREQ-1:0]      grant_oh;
  logic [FRAME_W-1:0]   grant_frame;

  // Round-robin pick: first valid index at or above rr_ptr, else wrap to the lowest valid below it.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    grant_frame = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!grant_found && req_valid[j] && (PTR_W'(j) >= rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(j);
        grant_oh[j] = 1'b1;
        grant_frame = req_frame[j*FRAME_W +: FRAME_W];
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!grant_found && req_valid[j] && (PTR_W'(j) < rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(j);
        grant_oh[j] = 1'b1;
        grant_frame = req_frame[j*FRAME_W +: FRAME_W];
      end
    end
  end

  // Next-state and output logic for the IDLE/START/WAIT_DONE/GAP sequencer.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    sel_d         = sel_q;
    frame_d       = frame_q;
    timer_d       = timer_q;
    gap_cnt_d     = gap_cnt_q;
    to_cnt_d      = to_cnt_q;
    req_ready     = '0;
    spi_start     = 1'b0;
    spi_sel       = '0;
    timeout_pulse = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = grant_oh;
        if (grant_found) begin
          frame_d  = grant_frame;
          sel_d    = grant_oh;
          rr_ptr_d = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
          state_d  = ST_START;
        end
      end

      ST_START: begin
        spi_start = 1'b1;
        spi_sel   = sel_q;
        timer_d   = '0;
        state_d   = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        spi_sel = sel_q;
        timer_d = timer_q + TMR_W'(1);
        if (spi_done) begin
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else if (timer_q == TMR_LAST) begin
          timeout_pulse = 1'b1;
          if (to_cnt_q != 8'hFF) begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts everything immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      frame_q   <= '0;
      timer_q   <= '0;
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_q     <= sel_d;
      frame_q   <= frame_d;
      timer_q   <= timer_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign spi_frame     = frame_q;
  assign arb_busy      = (state_q != ST_IDLE);
  assign timeout_count = to_cnt_q;

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Self-checking bench for spi_frame_arbiter: requesters and a simple frame
// engine are modelled here; expected grants are queued as stimulus is
// applied and popped whenever the arbiter issues spi_start.

module tb_spi_frame_arbiter;

  localparam int NREQ     = 2;
  localparam int FRAME_W  = 16;
  localparam int GAP      = 4;
  localparam int TMO      = 64;
  localparam int DONE_DLY = 40;

  logic                    clk = 1'b0;
  logic                    resetn = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ*FRAME_W-1:0] req_frame = '0;
  logic [NREQ-1:0]         req_ready;
  logic                    spi_start;
  logic [FRAME_W-1:0]      spi_frame;
  logic [NREQ-1:0]         spi_sel;
  logic                    spi_done = 1'b0;
  logic                    arb_busy;
  logic                    timeout_pulse;
  logic [7:0]              timeout_count;

  spi_frame_arbiter #(
    .NREQ(NREQ), .FRAME_W(FRAME_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_frame(req_frame),
    .req_ready(req_ready), .spi_start(spi_start), .spi_frame(spi_frame),
    .spi_sel(spi_sel), .spi_done(spi_done), .arb_busy(arb_busy),
    .timeout_pulse(timeout_pulse), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FRAME_W-1:0] frame;
    logic [NREQ-1:0]    sel;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int engineDelay = 0;
  int engineCnt = 0;
  bit engineArmed = 0;

  logic [NREQ-1:0]         holdMask = '0;
  logic [NREQ-1:0]         accLast = '0;
  bit                      pend = 0;
  logic [NREQ-1:0]         pendValid = '0;
  logic [NREQ*FRAME_W-1:0] pendFrame = '0;
  logic [NREQ-1:0]         pendHold = '0;

  int startCount = 0, toPulses = 0, accCount = 0;
  int startCyc = 0, accCyc = 0, toCyc = 0, selFallCyc = 0, busyFallCyc = 0, doneCyc = 0;
  logic [NREQ-1:0] prevSel = '0;
  logic            prevBusy = 1'b0;
  bit              chkOnehot = 0;

  // Count one comparison and report it when observed and required differ.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h required=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue a frame to be applied at the start of the next cycle.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*FRAME_W-1:0] f,
                               input logic [NREQ-1:0] h);
    pend      = 1;
    pendValid = v;
    pendFrame = f;
    pendHold  = h;
  endtask

  // Record which requester and frame the next spi_start must carry.
  task automatic expectGrant(input int idx, input logic [FRAME_W-1:0] f);
    exp_t e;
    e.frame = f;
    e.sel   = NREQ'(1) << idx;
    sbq.push_back(e);
  endtask

  // One clock: drive inputs just after the edge, then sample the settled outputs.
  task automatic stepCycle();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (accLast[i] && !holdMask[i]) req_valid[i] = 1'b0;
    end
    if (pend) begin
      req_valid = pendValid;
      req_frame = pendFrame;
      holdMask  = pendHold;
      pend      = 0;
    end
    spi_done = 1'b0;
    if (engineArmed) begin
      engineCnt--;
      if (engineCnt == 0) begin
        spi_done    = 1'b1;
        engineArmed = 0;
        doneCyc     = cyc;
      end
    end
    #1;
    accLast = req_valid & req_ready;
    if (|accLast) begin
      accCyc = cyc;
      accCount++;
    end
    if (spi_start) begin
      startCyc = cyc;
      startCount++;
      checkOutput("sb_pending", {31'b0, (sbq.size() > 0)}, 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("start_frame", {16'b0, spi_frame}, {16'b0, e.frame});
        checkOutput("start_sel", {30'b0, spi_sel}, {30'b0, e.sel});
      end
      if (engineDelay > 0) begin
        engineArmed = 1;
        engineCnt   = engineDelay;
      end
    end
    if (timeout_pulse) begin
      toCyc = cyc;
      toPulses++;
    end
    if (prevSel != '0 && spi_sel == '0) selFallCyc = cyc;
    if (prevBusy && !arb_busy) busyFallCyc = cyc;
    prevSel  = spi_sel;
    prevBusy = arb_busy;
    if (chkOnehot) begin
      checkOutput("ready_onehot", {31'b0, ($countones(req_ready) <= 1)}, 1);
      checkOutput("sel_onehot", {31'b0, ($countones(spi_sel) <= 1)}, 1);
    end
  endtask

  task automatic waitStarts(input int target, input int budget, input string tag);
    int n = 0;
    while (startCount < target && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, {31'b0, (startCount >= target)}, 1);
  endtask

  task automatic waitTimeouts(input int target, input int budget, input string tag);
    int n = 0;
    while (toPulses < target && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, {31'b0, (toPulses >= target)}, 1);
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    while (arb_busy && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, {31'b0, !arb_busy}, 1);
  endtask

  task automatic doReset();
    resetn      = 1'b0;
    req_valid   = '0;
    holdMask    = '0;
    pend        = 0;
    engineArmed = 0;
    spi_done    = 1'b0;
    repeat (3) stepCycle();
    resetn = 1'b1;
    repeat (2) stepCycle();
  endtask

  // Global time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence of scenarios.
  initial begin
    int base, p0, c0, s1;

    repeat (3) stepCycle();
    checkOutput("rst_ready", {30'b0, req_ready}, 0);
    checkOutput("rst_start", {31'b0, spi_start}, 0);
    checkOutput("rst_sel", {30'b0, spi_sel}, 0);
    checkOutput("rst_to_pulse", {31'b0, timeout_pulse}, 0);
    checkOutput("rst_to_count", {24'b0, timeout_count}, 0);
    checkOutput("rst_frame", {16'b0, spi_frame}, 0);
    checkOutput("rst_busy", {31'b0, arb_busy}, 0);
    resetn = 1'b1;
    repeat (2) stepCycle();

    $display("[TB] single frame");
    engineDelay = DONE_DLY;
    applyStimulus(2'b01, {16'h0000, 16'h00E3}, 2'b00);
    expectGrant(0, 16'h00E3);
    stepCycle();
    c0 = cyc;
    checkOutput("t1_ready", {30'b0, req_ready}, 32'h1);
    base = startCount;
    waitStarts(base + 1, 10, "t1_start_wait");
    checkOutput("t1_start_lat", startCyc - c0, 1);
    waitIdle(200, "t1_idle_wait");
    checkOutput("t1_sel_low", selFallCyc - startCyc, DONE_DLY + 1);
    checkOutput("t1_busy_low", busyFallCyc - startCyc, DONE_DLY + 1 + GAP);

    $display("[TB] simultaneous requests");
    doReset();
    engineDelay = 5;
    chkOnehot   = 1;
    applyStimulus(2'b11, {16'h5A01, 16'hA5A0}, 2'b11);
    expectGrant(0, 16'hA5A0);
    expectGrant(1, 16'h5A01);
    expectGrant(0, 16'hA5A0);
    expectGrant(1, 16'h5A01);
    base = startCount;
    waitStarts(base + 4, 200, "t2_start_wait");
    req_valid = '0;
    holdMask  = '0;
    waitIdle(100, "t2_idle_wait");
    chkOnehot = 0;
    checkOutput("t2_sb_empty", sbq.size(), 0);

    $display("[TB] back-to-back single source");
    engineDelay = DONE_DLY;
    applyStimulus(2'b01, {16'h0000, 16'h0F0F}, 2'b01);
    expectGrant(0, 16'h0F0F);
    expectGrant(0, 16'h0F0F);
    base = startCount;
    waitStarts(base + 1, 20, "t3_first_wait");
    s1 = startCyc;
    waitStarts(base + 2, 200, "t3_second_wait");
    req_valid = '0;
    holdMask  = '0;
    checkOutput("t3_restart", startCyc - doneCyc, GAP + 2);
    checkOutput("t3_sel_gap", startCyc - selFallCyc, GAP + 1);
    checkOutput("t3_period", startCyc - s1, DONE_DLY + GAP + 2);
    waitIdle(200, "t3_idle_wait");

    $display("[TB] timeout");
    engineDelay = 0;
    p0 = toPulses;
    applyStimulus(2'b10, {16'h0BAD, 16'h0000}, 2'b00);
    expectGrant(1, 16'h0BAD);
    base = startCount;
    waitStarts(base + 1, 20, "t4_start_wait");
    waitTimeouts(p0 + 1, TMO + 10, "t4_to_wait");
    checkOutput("t4_to_lat", toCyc - startCyc, TMO);
    stepCycle();
    checkOutput("t4_count", {24'b0, timeout_count}, 1);
    checkOutput("t4_sel_off", {30'b0, spi_sel}, 0);
    waitIdle(GAP + 10, "t4_idle_wait");
    checkOutput("t4_gap", busyFallCyc - toCyc, GAP + 1);
    engineDelay = 10;
    applyStimulus(2'b01, {16'h0000, 16'h0C0C}, 2'b00);
    expectGrant(0, 16'h0C0C);
    waitStarts(base + 2, 20, "t4_fresh_wait");
    waitIdle(100, "t4_fresh_idle");
    checkOutput("t4_one_pulse", toPulses - p0, 1);

    $display("[TB] done/timeout collision");
    engineDelay = TMO;
    p0 = toPulses;
    applyStimulus(2'b01, {16'h0000, 16'h7E57}, 2'b00);
    expectGrant(0, 16'h7E57);
    base = startCount;
    waitStarts(base + 1, 20, "t5_start_wait");
    waitIdle(TMO + GAP + 20, "t5_idle_wait");
    checkOutput("t5_no_pulse", toPulses - p0, 0);
    checkOutput("t5_count", {24'b0, timeout_count}, 1);
    checkOutput("t5_gap", busyFallCyc - startCyc, TMO + 1 + GAP);

    $display("[TB] timeout saturation");
    engineDelay = 0;
    p0 = toPulses;
    applyStimulus(2'b01, {16'h0000, 16'h5A75}, 2'b01);
    for (int k = 0; k < 300; k++) expectGrant(0, 16'h5A75);
    waitTimeouts(p0 + 300, 300 * (TMO + GAP + 4) + 50, "t6_to_wait");
    req_valid = '0;
    holdMask  = '0;
    waitIdle(GAP + 10, "t6_idle_wait");
    checkOutput("t6_count_sat", {24'b0, timeout_count}, 255);
    checkOutput("t6_sb_empty", sbq.size(), 0);

    $display("[TB] reset mid-frame");
    engineDelay = 0;
    applyStimulus(2'b01, {16'h0000, 16'h1234}, 2'b00);
    expectGrant(0, 16'h1234);
    base = startCount;
    waitStarts(base + 1, 20, "t7_start_wait");
    repeat (5) stepCycle();
    checkOutput("t7_pre_sel", {30'b0, spi_sel}, 32'h1);
    resetn = 1'b0;
    #1;
    checkOutput("t7_rst_sel", {30'b0, spi_sel}, 0);
    checkOutput("t7_rst_busy", {31'b0, arb_busy}, 0);
    checkOutput("t7_rst_count", {24'b0, timeout_count}, 0);
    checkOutput("t7_rst_frame", {16'b0, spi_frame}, 0);
    engineArmed = 0;
    repeat (2) stepCycle();
    resetn = 1'b1;
    stepCycle();
    engineDelay = 5;
    applyStimulus(2'b11, {16'hB002, 16'hB001}, 2'b11);
    expectGrant(0, 16'hB001);
    base = startCount;
    waitStarts(base + 1, 20, "t7_grant_wait");
    req_valid = '0;
    holdMask  = '0;
    waitIdle(100, "t7_idle_wait");
    checkOutput("t7_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
